// File: rtl/fetch_redirect_unit.sv
// Fetch-stage PC owner: increments, holds on stall, redirects on a taken branch
// and squashes wrong-path fetches. Optional taken-branch counter under BRANCH_STATS_EN.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          COUNT_WIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stallInput,
    input  logic                   branchTakenInput,
    input  logic [31:0]            branchTargetInput,
    output logic [31:0]            pcOutput,
    output logic [31:0]            pcPlus4Output,
    output logic                   flushOutput,
    output logic                   misalignOutput,
    output logic [COUNT_WIDTH-1:0] takenCountOutput
);

    // state       | meaning
    // ------------+-------------------------------------------------------
    // STATE_RUN   | normal fetch: increment, hold on stall, accept branches
    // STATE_FLUSH | post-redirect squash window; pc free-runs, branches ignored
    localparam logic [0:0] STATE_RUN   = 1'b0;
    localparam logic [0:0] STATE_FLUSH = 1'b1;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [0:0]  state_q;
    logic [2:0]  flush_cnt_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        flush_q;
    logic        misalign_q;
    logic        in_flush;
    logic        branch_accept;
    logic        flush_done;

    assign in_flush      = (state_q == STATE_FLUSH);
    assign branch_accept = !in_flush && branchTakenInput;
    assign flush_done    = in_flush && (flush_cnt_q == 3'd1);
    assign pc_plus4      = pc_q + 32'd4;

    // Stalls inside the flush window only create bubbles, so the pc keeps moving.
    always_comb begin
        pc_next = pc_q;
        if (branch_accept)
            pc_next = {branchTargetInput[31:2], 2'b00};
        else if (in_flush || !stallInput)
            pc_next = pc_plus4;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= STATE_RUN;
            flush_cnt_q <= 3'd0;
            flush_q     <= 1'b0;
        end else if (branch_accept) begin
            state_q     <= STATE_FLUSH;
            flush_cnt_q <= FLUSH_LOAD;
            flush_q     <= 1'b1;
        end else if (in_flush) begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
            if (flush_done) begin
                state_q <= STATE_RUN;
                flush_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_next;
            misalign_q <= branch_accept && (branchTargetInput[1:0] != 2'b00);
        end
    end

`ifdef BRANCH_STATS_EN
    logic [COUNT_WIDTH-1:0] taken_cnt_q;

    always_ff @(posedge clock) begin
        if (reset)
            taken_cnt_q <= '0;
        else if (branch_accept && (taken_cnt_q != '1))
            taken_cnt_q <= taken_cnt_q + 1'b1;
    end

    assign takenCountOutput = taken_cnt_q;
`else
    assign takenCountOutput = '0;
`endif

    assign pcOutput       = pc_q;
    assign pcPlus4Output  = pc_plus4;
    assign flushOutput    = flush_q;
    assign misalignOutput = misalign_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_fetch_redirect_unit;

    localparam int          FC = 2;
    localparam int          CW = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic          clock = 1'b0;
    logic          reset;
    logic          stallInput;
    logic          branchTakenInput;
    logic [31:0]   branchTargetInput;
    logic [31:0]   pcOutput;
    logic [31:0]   pcPlus4Output;
    logic          flushOutput;
    logic          misalignOutput;
    logic [CW-1:0] takenCountOutput;

    int total = 0;
    int bad   = 0;

    fetch_redirect_unit #(
        .RESET_PC    (RPC),
        .FLUSH_CYCLES(FC),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .stallInput       (stallInput),
        .branchTakenInput (branchTakenInput),
        .branchTargetInput(branchTargetInput),
        .pcOutput         (pcOutput),
        .pcPlus4Output    (pcPlus4Output),
        .flushOutput      (flushOutput),
        .misalignOutput   (misalignOutput),
        .takenCountOutput (takenCountOutput)
    );

    always #5 clock = ~clock;

    // Behavioural model: remaining squash cycles, pc as plain integer arithmetic.
    logic [31:0] m_pc;
    int          m_flush_left;
    logic        m_mis;
    int          m_count;
    bit          m_valid = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_pc = RPC; m_flush_left = 0; m_mis = 0; m_count = 0; m_valid = 1;
        end else if (m_valid) begin
            m_mis = 0;
            if (m_flush_left > 0) begin
                m_pc = m_pc + 4;
                m_flush_left = m_flush_left - 1;
            end else if (branchTakenInput) begin
                m_pc = branchTargetInput & 32'hFFFF_FFFC;
                m_flush_left = FC;
                m_mis = (branchTargetInput % 4) != 0;
                if (m_count < (1 << CW) - 1) m_count = m_count + 1;
            end else if (!stallInput) begin
                m_pc = m_pc + 4;
            end
        end
    end

    function automatic int exp_count();
`ifdef BRANCH_STATS_EN
        return m_count;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_valid) begin
            chk("model_pc", pcOutput, m_pc);
            chk("model_pc4", pcPlus4Output, m_pc + 32'd4);
            chk("model_flush", {31'd0, flushOutput}, {31'd0, m_flush_left > 0});
            chk("model_misalign", {31'd0, misalignOutput}, {31'd0, m_mis});
            chk("model_count", {{(32-CW){1'b0}}, takenCountOutput}, 32'(exp_count()));
        end
    end

    task automatic tick(input logic r, input logic s, input logic b, input logic [31:0] t);
        reset = r; stallInput = s; branchTakenInput = b; branchTargetInput = t;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1; stallInput = 0; branchTakenInput = 0; branchTargetInput = 0;
        tick(1, 0, 0, 0);
        tick(1, 1, 1, 32'h55);
        chk("rst_pc", pcOutput, 32'h0);
        chk("rst_flush", {31'd0, flushOutput}, 32'd0);
        chk("rst_mis", {31'd0, misalignOutput}, 32'd0);

        tick(0, 0, 0, 0); chk("free_4", pcOutput, 32'h4);
        tick(0, 0, 0, 0); chk("free_8", pcOutput, 32'h8);
        tick(0, 0, 0, 0); chk("free_c", pcOutput, 32'hC);
        chk("free_flush", {31'd0, flushOutput}, 32'd0);
        tick(0, 0, 0, 0); chk("pc_10", pcOutput, 32'h10);
        tick(0, 1, 0, 0); chk("stall_a", pcOutput, 32'h10);
        tick(0, 1, 0, 0); chk("stall_b", pcOutput, 32'h10);
        tick(0, 0, 0, 0); chk("after_stall", pcOutput, 32'h14);

        repeat (3) tick(0, 0, 0, 0);
        chk("pc_20", pcOutput, 32'h20);
        tick(0, 0, 1, 32'h100); chk("redir_pc", pcOutput, 32'h100);
        chk("redir_flush1", {31'd0, flushOutput}, 32'd1);
        tick(0, 0, 0, 0); chk("flush_pc2", pcOutput, 32'h104);
        chk("redir_flush2", {31'd0, flushOutput}, 32'd1);
        tick(0, 0, 0, 0); chk("run_pc", pcOutput, 32'h108);
        chk("run_flush", {31'd0, flushOutput}, 32'd0);

        tick(0, 1, 1, 32'h40); chk("br_over_stall", pcOutput, 32'h40);
        tick(0, 1, 1, 32'h80); chk("ign_br1", pcOutput, 32'h44);
        tick(0, 0, 1, 32'h80); chk("ign_br2", pcOutput, 32'h48);
        chk("ign_flush_end", {31'd0, flushOutput}, 32'd0);

        tick(0, 0, 1, 32'h103); chk("mis_pc", pcOutput, 32'h100);
        chk("mis_pulse", {31'd0, misalignOutput}, 32'd1);
        tick(0, 0, 0, 0); chk("mis_clear", {31'd0, misalignOutput}, 32'd0);
        tick(0, 0, 0, 0);

        tick(0, 0, 1, 32'hFFFF_FFF0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0); chk("pc_fff8", pcOutput, 32'hFFFF_FFF8);
        tick(0, 0, 0, 0); chk("pc_fffc", pcOutput, 32'hFFFF_FFFC);
        chk("pc4_wrap", pcPlus4Output, 32'h0);
        tick(0, 0, 0, 0); chk("pc_wrap", pcOutput, 32'h0);

        tick(0, 0, 1, 32'h200);
        tick(1, 0, 0, 0); chk("midflush_rst_pc", pcOutput, RPC);
        chk("midflush_rst_flush", {31'd0, flushOutput}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 32'h300 + 32'(i) * 32'h10);
            tick(0, 0, 0, 0);
            tick(0, 0, 0, 0);
        end
`ifdef BRANCH_STATS_EN
        chk("count3", {{(32-CW){1'b0}}, takenCountOutput}, 32'd3);
`else
        chk("count_tied", {{(32-CW){1'b0}}, takenCountOutput}, 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom();
            if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
            tick($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 25, t);
        end

        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
